// File: rtl/wb_pkg.sv
// Shared types and constants for the register-file write-back front end.
// The queue entry layout is fixed by the default data/index widths.
package wb_pkg;

  localparam int DATA_W = 16;
  localparam int REG_W  = 4;

  localparam logic [REG_W-1:0] R15_IDX = '0;

  typedef struct packed {
    logic              dst_en;
    logic [REG_W-1:0]  dst;
    logic [DATA_W-1:0] data;
    logic              r15_en;
    logic [DATA_W-1:0] r15_data;
  } wb_entry_t;

  // Destination write to index 0 shadows the special-register write.
  function automatic logic is_collision(wb_entry_t e);
    return e.dst_en & e.r15_en & (e.dst == R15_IDX);
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// In-order result queue with flush and a per-slot view of live entries.
// Pointers wrap modulo DEPTH; the occupancy count separates full from empty.
module wb_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push_i,
  input  wb_entry_t              entry_i,
  input  logic                   pop_i,
  input  logic                   flush_i,
  output wb_entry_t              head_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [DEPTH-1:0]       vld_o,
  output wb_entry_t              ents_o [DEPTH]
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  wb_entry_t         mem_q [DEPTH];
  wb_entry_t         mem_d [DEPTH];
  logic [AW-1:0]     wptr_q, wptr_d;
  logic [AW-1:0]     rptr_q, rptr_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              do_push;
  logic              do_pop;

  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign do_push = push_i & ~full_o & ~flush_i;
  assign do_pop  = pop_i & ~empty_o & ~flush_i;

  always_comb begin
    mem_d  = mem_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (flush_i) begin
      wptr_d = '0;
      rptr_d = '0;
      cnt_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wptr_q] = entry_i;
        wptr_d        = wptr_q + 1'b1;
      end
      if (do_pop) begin
        rptr_d = rptr_q + 1'b1;
      end
      cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      mem_q  <= mem_d;
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  // A slot is live when its distance from the read pointer is below count.
  always_comb begin
    vld_o = '0;
    for (int i = 0; i < DEPTH; i++) begin
      logic [AW-1:0] off;
      off      = AW'(i) - rptr_q;
      vld_o[i] = ({1'b0, off} < cnt_q);
    end
  end

  assign head_o  = mem_q[rptr_q];
  assign count_o = cnt_q;
  assign ents_o  = mem_q;

endmodule

// File: rtl/reg_writeback.sv
// Register-file write front end: arbitrates ALU and load results into a
// queue, drains one entry per cycle and publishes pending-write hazards.
module reg_writeback
  import wb_pkg::*;
#(
  parameter int dataSize = DATA_W,
  parameter int regSize  = REG_W,
  parameter int depth    = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      aluValid,
  output logic                      aluReady,
  input  logic                      aluDstEn,
  input  logic [regSize-1:0]        aluDst,
  input  logic [dataSize-1:0]       aluData,
  input  logic                      aluR15En,
  input  logic [dataSize-1:0]       aluR15Data,
  input  logic                      memValid,
  output logic                      memReady,
  input  logic [regSize-1:0]        memDst,
  input  logic [dataSize-1:0]       memData,
  input  logic                      flush,
  output logic                      wr,
  output logic [regSize-1:0]        regDst,
  output logic [dataSize-1:0]       regDstData,
  output logic                      wrR15,
  output logic [dataSize-1:0]       regR15Data,
  output logic [(1<<regSize)-1:0]   busyMask,
  output logic [$clog2(depth):0]    count
);

  localparam int REG_CNT = 1 << regSize;

  wb_entry_t          push_ent;
  wb_entry_t          head;
  wb_entry_t          ents [depth];
  logic [depth-1:0]   vld;
  logic               full;
  logic               empty;
  logic               push;
  logic               pop;

  logic                wr_q, wr_d;
  logic                wr_r15_q, wr_r15_d;
  logic [regSize-1:0]  dst_q, dst_d;
  logic [dataSize-1:0] data_q, data_d;
  logic [dataSize-1:0] r15_q, r15_d;

  // Loads win over ALU results; neither ready looks at its own valid.
  assign memReady = ~full & ~flush;
  assign aluReady = ~full & ~flush & ~memValid;
  assign push     = (memValid & memReady) | (aluValid & aluReady);
  assign pop      = ~empty & ~flush;

  always_comb begin
    push_ent = '0;
    if (memValid) begin
      push_ent.dst_en = 1'b1;
      push_ent.dst    = memDst;
      push_ent.data   = memData;
    end else begin
      push_ent.dst_en   = aluDstEn;
      push_ent.dst      = aluDst;
      push_ent.data     = aluData;
      push_ent.r15_en   = aluR15En;
      push_ent.r15_data = aluR15Data;
    end
  end

  wb_fifo #(
    .DEPTH (depth)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst),
    .push_i  (push),
    .entry_i (push_ent),
    .pop_i   (pop),
    .flush_i (flush),
    .head_o  (head),
    .count_o (count),
    .full_o  (full),
    .empty_o (empty),
    .vld_o   (vld),
    .ents_o  (ents)
  );

  always_comb begin
    wr_d     = 1'b0;
    wr_r15_d = 1'b0;
    dst_d    = dst_q;
    data_d   = data_q;
    r15_d    = r15_q;
    if (pop) begin
      wr_d     = head.dst_en;
      wr_r15_d = head.r15_en & ~is_collision(head);
      dst_d    = head.dst;
      data_d   = head.data;
      r15_d    = head.r15_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_q     <= 1'b0;
      wr_r15_q <= 1'b0;
      dst_q    <= '0;
      data_q   <= '0;
      r15_q    <= '0;
    end else begin
      wr_q     <= wr_d;
      wr_r15_q <= wr_r15_d;
      dst_q    <= dst_d;
      data_q   <= data_d;
      r15_q    <= r15_d;
    end
  end

  assign wr         = wr_q;
  assign wrR15      = wr_r15_q;
  assign regDst     = dst_q;
  assign regDstData = data_q;
  assign regR15Data = r15_q;

  // Hazard view: every live queue entry plus the strobe now in flight.
  always_comb begin
    busyMask = '0;
    for (int i = 0; i < depth; i++) begin
      if (vld[i]) begin
        if (ents[i].dst_en) busyMask[ents[i].dst] = 1'b1;
        if (ents[i].r15_en) busyMask[R15_IDX] = 1'b1;
      end
    end
    if (wr_q) busyMask[dst_q] = 1'b1;
    if (wr_r15_q) busyMask[R15_IDX] = 1'b1;
  end

endmodule

// File: tb/tb_reg_writeback.sv
// Bench for reg_writeback: directed vector table, reset sequence,
// then random traffic against a queue-based reference model.
module tb_reg_writeback;

  logic        clk = 1'b0;
  logic        rst;
  logic        aluValid, aluReady, aluDstEn, aluR15En;
  logic [3:0]  aluDst;
  logic [15:0] aluData, aluR15Data;
  logic        memValid, memReady;
  logic [3:0]  memDst;
  logic [15:0] memData;
  logic        flush;
  logic        wr, wrR15;
  logic [3:0]  regDst;
  logic [15:0] regDstData, regR15Data, busyMask;
  logic [2:0]  count;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  reg_writeback dut (
    .clk(clk), .rst(rst),
    .aluValid(aluValid), .aluReady(aluReady), .aluDstEn(aluDstEn),
    .aluDst(aluDst), .aluData(aluData), .aluR15En(aluR15En),
    .aluR15Data(aluR15Data),
    .memValid(memValid), .memReady(memReady), .memDst(memDst),
    .memData(memData), .flush(flush),
    .wr(wr), .regDst(regDst), .regDstData(regDstData), .wrR15(wrR15),
    .regR15Data(regR15Data), .busyMask(busyMask), .count(count)
  );

  typedef struct {
    logic        av, aden;
    logic [3:0]  adst;
    logic [15:0] adat;
    logic        aren;
    logic [15:0] ardat;
    logic        mv;
    logic [3:0]  mdst;
    logic [15:0] mdat;
    logic        fl;
    logic        emr, ear, ewr;
    logic [3:0]  edst;
    logic [15:0] edat;
    logic        ew15;
    logic [15:0] er15;
    logic [2:0]  ecnt;
    logic [15:0] ebusy;
  } vec_t;

  typedef struct {
    logic        den;
    logic [3:0]  dst;
    logic [15:0] dat;
    logic        ren;
    logic [15:0] rdat;
  } ent_t;

  vec_t tbl[$];

  // reference model state
  ent_t        mq[$];
  logic        m_wr, m_w15;
  logic [3:0]  m_dst;
  logic [15:0] m_dat, m_r15;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(
    logic av, logic aden, logic [3:0] adst, logic [15:0] adat,
    logic aren, logic [15:0] ardat,
    logic mv, logic [3:0] mdst, logic [15:0] mdat, logic fl,
    logic emr, logic ear, logic ewr, logic [3:0] edst,
    logic [15:0] edat, logic ew15, logic [15:0] er15,
    logic [2:0] ecnt, logic [15:0] ebusy);
    vec_t v;
    v.av = av; v.aden = aden; v.adst = adst; v.adat = adat;
    v.aren = aren; v.ardat = ardat;
    v.mv = mv; v.mdst = mdst; v.mdat = mdat; v.fl = fl;
    v.emr = emr; v.ear = ear; v.ewr = ewr; v.edst = edst;
    v.edat = edat; v.ew15 = ew15; v.er15 = er15;
    v.ecnt = ecnt; v.ebusy = ebusy;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    aluValid = v.av; aluDstEn = v.aden; aluDst = v.adst;
    aluData = v.adat; aluR15En = v.aren; aluR15Data = v.ardat;
    memValid = v.mv; memDst = v.mdst; memData = v.mdat;
    flush = v.fl;
  endtask

  task automatic idle_in();
    aluValid = 0; aluDstEn = 0; aluDst = 0; aluData = 0;
    aluR15En = 0; aluR15Data = 0;
    memValid = 0; memDst = 0; memData = 0; flush = 0;
  endtask

  task automatic alu_push(input logic [3:0] d, input logic [15:0] x);
    idle_in();
    aluValid = 1; aluDstEn = 1; aluDst = d; aluData = x;
    @(posedge clk); #1;
  endtask

  function automatic logic [15:0] mbusy();
    logic [15:0] b;
    b = '0;
    foreach (mq[i]) begin
      if (mq[i].den) b[mq[i].dst] = 1'b1;
      if (mq[i].ren) b[0] = 1'b1;
    end
    if (m_wr) b[m_dst] = 1'b1;
    if (m_w15) b[0] = 1'b1;
    return b;
  endfunction

  task automatic chk_regs(input string tag, input vec_t v);
    chk({tag, ".wr"}, 32'(wr), 32'(v.ewr));
    chk({tag, ".regDst"}, 32'(regDst), 32'(v.edst));
    chk({tag, ".regDstData"}, 32'(regDstData), 32'(v.edat));
    chk({tag, ".wrR15"}, 32'(wrR15), 32'(v.ew15));
    chk({tag, ".regR15Data"}, 32'(regR15Data), 32'(v.er15));
    chk({tag, ".count"}, 32'(count), 32'(v.ecnt));
    chk({tag, ".busyMask"}, 32'(busyMask), 32'(v.ebusy));
  endtask

  initial begin
    idle_in();
    rst = 0;
    #1;
    chk("rst.wr", 32'(wr), 0);
    chk("rst.wrR15", 32'(wrR15), 0);
    chk("rst.regDst", 32'(regDst), 0);
    chk("rst.regDstData", 32'(regDstData), 0);
    chk("rst.regR15Data", 32'(regR15Data), 0);
    chk("rst.count", 32'(count), 0);
    chk("rst.busyMask", 32'(busyMask), 0);
    chk("rst.memReady", 32'(memReady), 1);
    chk("rst.aluReady", 32'(aluReady), 1);
    memValid = 1;
    #1;
    chk("rst.aluReady_memValid", 32'(aluReady), 0);
    memValid = 0;
    @(negedge clk); rst = 1;
    @(posedge clk); #1;

    //      av ad dst adat   ar ardat  mv md mdat   fl  mr ar wr dst edat   w15 er15   cnt busy
    tbl.push_back(mk(1,1,3,16'h1234,0,16'h0,  0,0,16'h0,   0, 1,1,0,0, 16'h0000,0,16'h0000,1,16'h0008));
    tbl.push_back(mk(0,0,0,16'h0,   0,16'h0,  0,0,16'h0,   0, 1,1,1,3, 16'h1234,0,16'h0000,0,16'h0008));
    tbl.push_back(mk(0,0,0,16'h0,   0,16'h0,  0,0,16'h0,   0, 1,1,0,3, 16'h1234,0,16'h0000,0,16'h0000));
    tbl.push_back(mk(1,1,6,16'h6666,0,16'h0,  1,5,16'hBEEF,0, 1,0,0,3, 16'h1234,0,16'h0000,1,16'h0020));
    tbl.push_back(mk(1,1,6,16'h6666,0,16'h0,  0,0,16'h0,   0, 1,1,1,5, 16'hBEEF,0,16'h0000,1,16'h0060));
    tbl.push_back(mk(0,0,0,16'h0,   0,16'h0,  0,0,16'h0,   0, 1,1,1,6, 16'h6666,0,16'h0000,0,16'h0040));
    tbl.push_back(mk(1,1,0,16'h0A0A,1,16'hCCCC,0,0,16'h0,  0, 1,1,0,6, 16'h6666,0,16'h0000,1,16'h0001));
    tbl.push_back(mk(0,0,0,16'h0,   0,16'h0,  0,0,16'h0,   0, 1,1,1,0, 16'h0A0A,0,16'hCCCC,0,16'h0001));
    tbl.push_back(mk(1,1,2,16'h2222,1,16'hCCCC,0,0,16'h0,  0, 1,1,0,0, 16'h0A0A,0,16'hCCCC,1,16'h0005));
    tbl.push_back(mk(0,0,0,16'h0,   0,16'h0,  0,0,16'h0,   0, 1,1,1,2, 16'h2222,1,16'hCCCC,0,16'h0005));
    tbl.push_back(mk(1,0,7,16'h7777,0,16'h0,  0,0,16'h0,   0, 1,1,0,2, 16'h2222,0,16'hCCCC,1,16'h0000));
    tbl.push_back(mk(0,0,0,16'h0,   0,16'h0,  0,0,16'h0,   0, 1,1,0,7, 16'h7777,0,16'h0000,0,16'h0000));
    tbl.push_back(mk(1,0,9,16'h9999,1,16'h5A5A,0,0,16'h0,  0, 1,1,0,7, 16'h7777,0,16'h0000,1,16'h0001));
    tbl.push_back(mk(0,0,0,16'h0,   0,16'h0,  0,0,16'h0,   0, 1,1,0,9, 16'h9999,1,16'h5A5A,0,16'h0001));
    tbl.push_back(mk(1,1,4,16'h4444,0,16'h0,  0,0,16'h0,   0, 1,1,0,9, 16'h9999,0,16'h5A5A,1,16'h0010));
    tbl.push_back(mk(1,1,8,16'h8888,0,16'h0,  0,0,16'h0,   1, 0,0,0,9, 16'h9999,0,16'h5A5A,0,16'h0000));
    tbl.push_back(mk(0,0,0,16'h0,   0,16'h0,  0,0,16'h0,   0, 1,1,0,9, 16'h9999,0,16'h5A5A,0,16'h0000));
    tbl.push_back(mk(1,1,1,16'h1111,0,16'h0,  0,0,16'h0,   0, 1,1,0,9, 16'h9999,0,16'h5A5A,1,16'h0002));
    tbl.push_back(mk(1,1,10,16'hAAAA,0,16'h0, 0,0,16'h0,   0, 1,1,1,1, 16'h1111,0,16'h0000,1,16'h0402));
    tbl.push_back(mk(0,0,0,16'h0,   0,16'h0,  0,0,16'h0,   1, 0,0,0,1, 16'h1111,0,16'h0000,0,16'h0000));
    tbl.push_back(mk(0,0,0,16'h0,   0,16'h0,  1,11,16'hD000,0,1,0,0,1, 16'h1111,0,16'h0000,1,16'h0800));
    tbl.push_back(mk(0,0,0,16'h0,   0,16'h0,  1,12,16'hD001,0,1,0,1,11,16'hD000,0,16'h0000,1,16'h1800));
    tbl.push_back(mk(0,0,0,16'h0,   0,16'h0,  1,13,16'hD002,0,1,0,1,12,16'hD001,0,16'h0000,1,16'h3000));
    tbl.push_back(mk(0,0,0,16'h0,   0,16'h0,  1,14,16'hD003,0,1,0,1,13,16'hD002,0,16'h0000,1,16'h6000));
    tbl.push_back(mk(0,0,0,16'h0,   0,16'h0,  1,15,16'hD004,0,1,0,1,14,16'hD003,0,16'h0000,1,16'hC000));
    tbl.push_back(mk(0,0,0,16'h0,   0,16'h0,  1,1,16'hD005, 0,1,0,1,15,16'hD004,0,16'h0000,1,16'h8002));
    tbl.push_back(mk(0,0,0,16'h0,   0,16'h0,  0,0,16'h0,   0, 1,1,1,1, 16'hD005,0,16'h0000,0,16'h0002));
    tbl.push_back(mk(0,0,0,16'h0,   0,16'h0,  0,0,16'h0,   0, 1,1,0,1, 16'hD005,0,16'h0000,0,16'h0000));

    for (int i = 0; i < tbl.size(); i++) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      drive(tbl[i]);
      #3;
      chk({tag, ".memReady"}, 32'(memReady), 32'(tbl[i].emr));
      chk({tag, ".aluReady"}, 32'(aluReady), 32'(tbl[i].ear));
      @(posedge clk); #1;
      chk_regs(tag, tbl[i]);
    end

    // reset while a strobe is high and an entry is queued
    alu_push(4'd7, 16'h7007);
    alu_push(4'd8, 16'h8008);
    idle_in();
    chk("mid.wr_before", 32'(wr), 1);
    chk("mid.count_before", 32'(count), 1);
    #2 rst = 0;
    #1;
    chk("mid.wr", 32'(wr), 0);
    chk("mid.wrR15", 32'(wrR15), 0);
    chk("mid.count", 32'(count), 0);
    chk("mid.busyMask", 32'(busyMask), 0);
    chk("mid.regDst", 32'(regDst), 0);
    @(negedge clk); rst = 1;
    @(posedge clk); #1;
    alu_push(4'd3, 16'h1234);
    idle_in();
    chk("post.count", 32'(count), 1);
    chk("post.busy", 32'(busyMask), 32'h0008);
    chk("post.wr0", 32'(wr), 0);
    @(posedge clk); #1;
    chk("post.wr", 32'(wr), 1);
    chk("post.regDst", 32'(regDst), 3);
    chk("post.regDstData", 32'(regDstData), 32'h1234);
    chk("post.busy1", 32'(busyMask), 32'h0008);
    @(posedge clk); #1;
    chk("post.wr_drop", 32'(wr), 0);
    chk("post.busy2", 32'(busyMask), 0);

    // random traffic against the reference model
    rst = 0;
    #1;
    mq.delete();
    m_wr = 0; m_w15 = 0; m_dst = 0; m_dat = 0; m_r15 = 0;
    @(negedge clk); rst = 1;
    @(posedge clk); #1;
    for (int c = 0; c < 400; c++) begin
      logic m_mr, m_ar;
      ent_t e;
      aluValid   = ($urandom_range(99) < 60);
      aluDstEn   = ($urandom_range(99) < 80);
      aluDst     = 4'($urandom_range(15));
      aluData    = 16'($urandom);
      aluR15En   = ($urandom_range(99) < 30);
      aluR15Data = 16'($urandom);
      memValid   = ($urandom_range(99) < 35);
      memDst     = 4'($urandom_range(15));
      memData    = 16'($urandom);
      flush      = ($urandom_range(99) < 6);
      m_mr = (mq.size() < 4) && !flush;
      m_ar = m_mr && !memValid;
      #3;
      chk("rnd.memReady", 32'(memReady), 32'(m_mr));
      chk("rnd.aluReady", 32'(aluReady), 32'(m_ar));
      @(posedge clk);
      if (!flush && mq.size() > 0) begin
        e = mq.pop_front();
        m_wr  = e.den;
        m_w15 = e.ren && !(e.den && e.dst == 4'd0);
        m_dst = e.dst;
        m_dat = e.dat;
        m_r15 = e.rdat;
      end else begin
        m_wr  = 0;
        m_w15 = 0;
      end
      if (flush) mq.delete();
      if (memValid && m_mr) begin
        e.den = 1; e.dst = memDst; e.dat = memData;
        e.ren = 0; e.rdat = 0;
        mq.push_back(e);
      end else if (aluValid && m_ar) begin
        e.den = aluDstEn; e.dst = aluDst; e.dat = aluData;
        e.ren = aluR15En; e.rdat = aluR15Data;
        mq.push_back(e);
      end
      #1;
      chk("rnd.wr", 32'(wr), 32'(m_wr));
      chk("rnd.wrR15", 32'(wrR15), 32'(m_w15));
      chk("rnd.regDst", 32'(regDst), 32'(m_dst));
      chk("rnd.regDstData", 32'(regDstData), 32'(m_dat));
      chk("rnd.regR15Data", 32'(regR15Data), 32'(m_r15));
      chk("rnd.count", 32'(count), 32'(mq.size()));
      chk("rnd.busyMask", 32'(busyMask), 32'(mbusy()));
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
